// File: rtl/btb_lookup.sv
// 4-way fully-associative BTB: registered fetch prediction (1 cycle, held on stall, cleared on flush),
// combinational WB-port lookup, and per-way writes with a 3-bit tree pseudo-LRU.
module btb_lookup #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  output logic [1:0]        pred_way,
  output logic [1:0]        pred_ctr,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_target,
  output logic              wb_hit,
  output logic [1:0]        wb_way,
  output logic [1:0]        wb_ctr,
  output logic [1:0]        lru,
  input  logic [3:0]        tag_write,
  input  logic [3:0]        data_write,
  input  logic [3:0]        pred_write,
  input  logic [1:0]        pred_update,
  input  logic              lru_write
);
  localparam int N = 4;

  logic [N-1:0]      valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q [N];
  logic [ADDR_W-1:0] tag_d [N];
  logic [ADDR_W-1:0] target_q [N];
  logic [ADDR_W-1:0] target_d [N];
  logic [1:0]        ctr_q [N];
  logic [1:0]        ctr_d [N];
  logic [2:0]        plru_q, plru_d;   // {b2, b1, b0}

  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [ADDR_W-1:0] pred_target_q, pred_target_d;
  logic              pred_hit_q, pred_hit_d;
  logic [1:0]        pred_way_q, pred_way_d;
  logic [1:0]        pred_ctr_q, pred_ctr_d;

  logic       f_hit, w_hit;
  logic [1:0] f_way, w_way;
  logic [3:0] wr_any;
  logic [1:0] wr_way;
  logic       touch_en;
  logic [1:0] touch_way;

  // Descending scan so the lowest matching way has the final say.
  always_comb begin
    f_hit = 1'b0;
    f_way = 2'd0;
    w_hit = 1'b0;
    w_way = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == fetch_pc) begin
        f_hit = 1'b1;
        f_way = 2'(i);
      end
      if (valid_q[i] && tag_q[i] == wb_pc) begin
        w_hit = 1'b1;
        w_way = 2'(i);
      end
    end
  end

  assign wb_hit = w_hit;
  assign wb_way = w_way;
  assign wb_ctr = ctr_q[w_way];
  assign lru    = plru_q[0] ? {1'b1, plru_q[2]} : {1'b0, plru_q[1]};

  always_comb begin
    wr_any = tag_write | data_write | pred_write;
    wr_way = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (wr_any[i]) wr_way = 2'(i);
    end
  end

  // A WB touch takes priority over the fetch-hit touch in the same cycle.
  always_comb begin
    touch_en  = 1'b0;
    touch_way = 2'd0;
    if (lru_write) begin
      touch_en  = 1'b1;
      touch_way = wr_way;
    end else if (fetch_valid && f_hit && !stall && !flush) begin
      touch_en  = 1'b1;
      touch_way = f_way;
    end
    plru_d = plru_q;
    if (touch_en) begin
      plru_d[0] = ~touch_way[1];
      if (!touch_way[1]) plru_d[1] = ~touch_way[0];
      else               plru_d[2] = ~touch_way[0];
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    for (int i = 0; i < N; i++) begin
      if (tag_write[i]) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = wb_pc;
        ctr_d[i]   = pred_update;
      end
      if (data_write[i]) target_d[i] = wb_target;
      if (pred_write[i]) ctr_d[i]    = pred_update;
    end
  end

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_hit_d    = pred_hit_q;
    pred_way_d    = pred_way_q;
    pred_ctr_d    = pred_ctr_q;
    if (flush || (!stall && !fetch_valid)) begin
      pred_valid_d  = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      pred_hit_d    = 1'b0;
      pred_way_d    = 2'd0;
      pred_ctr_d    = 2'd0;
    end else if (!stall) begin
      pred_valid_d  = 1'b1;
      pred_hit_d    = f_hit;
      pred_way_d    = f_way;
      pred_ctr_d    = f_hit ? ctr_q[f_way] : 2'd0;
      pred_target_d = f_hit ? target_q[f_way] : '0;
      pred_taken_d  = f_hit && ctr_q[f_way][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      plru_q        <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_hit_q    <= 1'b0;
      pred_way_q    <= 2'd0;
      pred_ctr_q    <= 2'd0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd0;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      plru_q        <= plru_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_hit_q    <= pred_hit_d;
      pred_way_q    <= pred_way_d;
      pred_ctr_q    <= pred_ctr_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_hit    = pred_hit_q;
  assign pred_way    = pred_way_q;
  assign pred_ctr    = pred_ctr_q;

  a_tag_write_onehot0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(tag_write));
  a_data_write_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(data_write));
  a_pred_write_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pred_write));
endmodule

// File: tb/tb_btb_lookup.sv
// Bench for btb_lookup: directed vector table followed by random traffic against a reference model.
module tb_btb_lookup;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pred_valid, pred_taken, pred_hit;
  logic [15:0] pred_target;
  logic [1:0]  pred_way, pred_ctr;
  logic [15:0] wb_pc = '0;
  logic [15:0] wb_target = '0;
  logic        wb_hit;
  logic [1:0]  wb_way, wb_ctr, lru;
  logic [3:0]  tag_write = '0;
  logic [3:0]  data_write = '0;
  logic [3:0]  pred_write = '0;
  logic [1:0]  pred_update = '0;
  logic        lru_write = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btb_lookup #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .stall(stall), .flush(flush), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_hit(pred_hit), .pred_way(pred_way), .pred_ctr(pred_ctr),
    .wb_pc(wb_pc), .wb_target(wb_target), .wb_hit(wb_hit), .wb_way(wb_way), .wb_ctr(wb_ctr),
    .lru(lru), .tag_write(tag_write), .data_write(data_write), .pred_write(pred_write),
    .pred_update(pred_update), .lru_write(lru_write)
  );

  typedef struct packed {
    logic        fv;
    logic [15:0] fpc;
    logic        st;
    logic        fl;
    logic [15:0] wpc;
    logic [15:0] wtgt;
    logic [3:0]  tw;
    logic [3:0]  dw;
    logic [3:0]  pw;
    logic [1:0]  pu;
    logic        lw;
    logic        x_wh;
    logic [1:0]  x_ww;
    logic [1:0]  x_wc;
    logic [1:0]  x_lru;
    logic        x_pv;
    logic        x_ph;
    logic        x_pt;
    logic [15:0] x_ptgt;
    logic [1:0]  x_pway;
    logic [1:0]  x_pctr;
  } vec_t;

  // Reference model: plain per-way arrays and the three tree bits.
  logic        m_valid [4];
  logic [15:0] m_tag [4];
  logic [15:0] m_tgt [4];
  logic [1:0]  m_ctr [4];
  logic        m_b0, m_b1, m_b2;
  logic        mp_valid, mp_taken, mp_hit;
  logic [15:0] mp_tgt;
  logic [1:0]  mp_way, mp_ctr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = '0;
    end
    {m_b0, m_b1, m_b2} = 3'b000;
    {mp_valid, mp_taken, mp_hit, mp_tgt, mp_way, mp_ctr} = '0;
  endtask

  task automatic m_find(input logic [15:0] pc, output logic h, output logic [1:0] w);
    h = 1'b0;
    w = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!h && m_valid[i] && m_tag[i] == pc) begin
        h = 1'b1;
        w = 2'(i);
      end
  endtask

  function automatic logic [1:0] m_victim();
    return m_b0 ? {1'b1, m_b2} : {1'b0, m_b1};
  endfunction

  task automatic m_touch(input logic [1:0] w);
    m_b0 = ~w[1];
    if (w[1]) m_b2 = ~w[0];
    else      m_b1 = ~w[0];
  endtask

  task automatic m_advance();
    logic fh;
    logic [1:0] fw, ww;
    logic [3:0] mask;
    m_find(fetch_pc, fh, fw);
    if (flush || (!stall && !fetch_valid)) begin
      {mp_valid, mp_taken, mp_hit, mp_tgt, mp_way, mp_ctr} = '0;
    end else if (!stall) begin
      mp_valid = 1'b1;
      mp_hit   = fh;
      mp_way   = fh ? fw : 2'd0;
      mp_ctr   = fh ? m_ctr[fw] : 2'd0;
      mp_tgt   = fh ? m_tgt[fw] : 16'd0;
      mp_taken = fh && (m_ctr[fw] >= 2'd2);
    end
    mask = tag_write | data_write | pred_write;
    ww = 2'd0;
    for (int i = 0; i < 4; i++) if (mask[i]) ww = 2'(i);
    if (lru_write) m_touch(ww);
    else if (fetch_valid && fh && !stall && !flush) m_touch(fw);
    for (int i = 0; i < 4; i++) begin
      if (tag_write[i]) begin m_valid[i] = 1'b1; m_tag[i] = wb_pc; m_ctr[i] = pred_update; end
      if (data_write[i]) m_tgt[i] = wb_target;
      if (pred_write[i]) m_ctr[i] = pred_update;
    end
  endtask

  task automatic apply(input vec_t v);
    fetch_valid = v.fv; fetch_pc = v.fpc; stall = v.st; flush = v.fl;
    wb_pc = v.wpc; wb_target = v.wtgt; tag_write = v.tw; data_write = v.dw;
    pred_write = v.pw; pred_update = v.pu; lru_write = v.lw;
  endtask

  // Combinational checks at the falling edge, registered checks 1 after the rising edge.
  task automatic tick(input bit use_tbl, input vec_t v);
    logic mh, eh;
    logic [1:0] mw, ew, ec, el;
    @(negedge clk);
    m_find(wb_pc, mh, mw);
    if (use_tbl) begin
      eh = v.x_wh; ew = v.x_ww; ec = v.x_wc; el = v.x_lru;
    end else begin
      eh = mh; ew = mh ? mw : 2'd0; ec = m_ctr[ew]; el = m_victim();
    end
    chk("wb_hit", 32'(wb_hit), 32'(eh));
    chk("wb_way", 32'(wb_way), 32'(ew));
    chk("wb_ctr", 32'(wb_ctr), 32'(ec));
    chk("lru",    32'(lru),    32'(el));
    m_advance();
    @(posedge clk);
    #1;
    if (use_tbl) begin
      chk("pred_valid",  32'(pred_valid),  32'(v.x_pv));
      chk("pred_hit",    32'(pred_hit),    32'(v.x_ph));
      chk("pred_taken",  32'(pred_taken),  32'(v.x_pt));
      chk("pred_target", 32'(pred_target), 32'(v.x_ptgt));
      chk("pred_way",    32'(pred_way),    32'(v.x_pway));
      chk("pred_ctr",    32'(pred_ctr),    32'(v.x_pctr));
    end else begin
      chk("m_pred_valid",  32'(pred_valid),  32'(mp_valid));
      chk("m_pred_hit",    32'(pred_hit),    32'(mp_hit));
      chk("m_pred_taken",  32'(pred_taken),  32'(mp_taken));
      chk("m_pred_target", 32'(pred_target), 32'(mp_tgt));
      chk("m_pred_way",    32'(pred_way),    32'(mp_way));
      chk("m_pred_ctr",    32'(pred_ctr),    32'(mp_ctr));
    end
  endtask

  vec_t tv[$];
  logic [15:0] pool [6] = '{16'h3000, 16'h3100, 16'h3200, 16'h3300, 16'h3400, 16'h3500};

  initial begin
    // fv fpc st fl wpc wtgt tw dw pw pu lw | wh ww wc lru | pv ph pt ptgt pway pctr
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h3000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b0,2'd0,2'd0,2'd0, 1'b1,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h3000,16'h3040,4'h1,4'h1,4'h0,2'd1,1'b1, 1'b0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h3000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd0,2'd1,2'd2, 1'b1,1'b1,1'b0,16'h3040,2'd0,2'd1});
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h3000,16'h0000,4'h0,4'h0,4'h1,2'd2,1'b0, 1'b1,2'd0,2'd1,2'd2, 1'b1,1'b1,1'b0,16'h3040,2'd0,2'd1});
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h3000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd0,2'd2,2'd2, 1'b1,1'b1,1'b1,16'h3040,2'd0,2'd2});
    tv.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h3100,16'h3140,4'h2,4'h2,4'h0,2'd3,1'b1, 1'b0,2'd0,2'd2,2'd2, 1'b0,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h3200,16'h3240,4'h4,4'h4,4'h0,2'd0,1'b1, 1'b0,2'd0,2'd2,2'd2, 1'b0,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b0,16'h0000,1'b0,1'b0,16'h3300,16'h3340,4'h8,4'h8,4'h0,2'd1,1'b1, 1'b0,2'd0,2'd2,2'd0, 1'b0,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h3300,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd3,2'd1,2'd0, 1'b1,1'b1,1'b1,16'h3040,2'd0,2'd2});
    tv.push_back('{1'b1,16'h3200,1'b0,1'b0,16'h3500,16'h3540,4'h4,4'h4,4'h0,2'd2,1'b1, 1'b0,2'd0,2'd2,2'd2, 1'b1,1'b1,1'b0,16'h3240,2'd2,2'd0});
    tv.push_back('{1'b1,16'h3200,1'b0,1'b0,16'h3500,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd2,2'd2,2'd1, 1'b1,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b1,16'h4000,1'b0,1'b0,16'h4000,16'h4040,4'h2,4'h2,4'h0,2'd3,1'b1, 1'b0,2'd0,2'd2,2'd1, 1'b1,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b1,16'h4000,1'b0,1'b0,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b1,1'b1,1'b1,16'h4040,2'd1,2'd3});
    tv.push_back('{1'b1,16'h3000,1'b1,1'b0,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b1,1'b1,1'b1,16'h4040,2'd1,2'd3});
    tv.push_back('{1'b1,16'h3300,1'b1,1'b0,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b1,1'b1,1'b1,16'h4040,2'd1,2'd3});
    tv.push_back('{1'b1,16'h1234,1'b1,1'b0,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b1,1'b1,1'b1,16'h4040,2'd1,2'd3});
    tv.push_back('{1'b1,16'h3000,1'b1,1'b1,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b0,1'b0,1'b0,16'h0000,2'd0,2'd0});
    tv.push_back('{1'b1,16'h3000,1'b0,1'b0,16'h4000,16'h0000,4'h0,4'h0,4'h0,2'd0,1'b0, 1'b1,2'd1,2'd3,2'd3, 1'b1,1'b1,1'b1,16'h3040,2'd0,2'd2});

    m_reset();
    #1;
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_target", 32'(pred_target), 32'd0);
    chk("rst_wb_hit", 32'(wb_hit), 32'd0);
    chk("rst_lru", 32'(lru), 32'd0);
    #12;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    foreach (tv[k]) begin
      apply(tv[k]);
      tick(1'b1, tv[k]);
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    wb_pc = 16'h3000;
    #1;
    m_reset();
    chk("arst_pred_valid", 32'(pred_valid), 32'd0);
    chk("arst_pred_hit", 32'(pred_hit), 32'd0);
    chk("arst_pred_taken", 32'(pred_taken), 32'd0);
    chk("arst_pred_target", 32'(pred_target), 32'd0);
    chk("arst_wb_hit", 32'(wb_hit), 32'd0);
    chk("arst_lru", 32'(lru), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    apply('0);
    fetch_valid = 1'b1;
    fetch_pc = 16'h3000;
    tick(1'b0, '0);
    chk("post_rst_pred_valid", 32'(pred_valid), 32'd1);
    chk("post_rst_pred_hit", 32'(pred_hit), 32'd0);

    for (int n = 0; n < 400; n++) begin
      int w;
      fetch_valid = ($urandom % 4) != 0;
      fetch_pc    = pool[$urandom % 6];
      stall       = ($urandom % 5) == 0;
      flush       = ($urandom % 8) == 0;
      wb_pc       = pool[$urandom % 6];
      wb_target   = 16'($urandom);
      pred_update = 2'($urandom);
      tag_write = '0; data_write = '0; pred_write = '0; lru_write = 1'b0;
      if ($urandom % 2 == 1) begin
        w = int'($urandom % 4);
        tag_write  = ($urandom % 2 == 1) ? 4'(1 << w) : 4'b0;
        data_write = ($urandom % 2 == 1) ? 4'(1 << w) : 4'b0;
        pred_write = ($urandom % 3 == 0) ? 4'(1 << w) : 4'b0;
        lru_write  = ((tag_write | data_write | pred_write) != 4'b0) && ($urandom % 2 == 1);
      end
      tick(1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_lookup.md
# btb_lookup

Fetch-side reader and storage for the 4-way fully-associative branch target buffer. It holds tag, target, valid and 2-bit counter state per way. It delivers a registered taken/target prediction to fetch, plus way/counter metadata that travels down the pipeline. It also gives combinational WB-port lookup results to the BTB update logic, and applies the per-way write enables that logic returns.

## Interface
- ADDR_W, 16, PC / tag / target width
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch_pc is a real lookup this cycle
- fetch_pc  in  ADDR_W  PC being fetched
- stall  in  1  hold registered fetch outputs and skip the fetch LRU touch
- flush  in  1  squash registered fetch outputs
- pred_valid  out  1  registered; the fetch outputs below are meaningful
- pred_taken  out  1  registered; hit and counter[1]=1
- pred_target  out  ADDR_W  registered; target of the hit way, 0 on miss
- pred_hit  out  1  registered fetch hit, carried to WB as the "hit" flag
- pred_way  out  2  registered hit way
- pred_ctr  out  2  registered counter of the hit way
- wb_pc  in  ADDR_W  PC of the branch in WB
- wb_target  in  ADDR_W  resolved target of the branch in WB
- wb_hit  out  1  combinational: wb_pc matches a valid way
- wb_way  out  2  combinational: matching way, 0 on miss (drives target_mux_sel)
- wb_ctr  out  2  combinational: counter of wb_way (drives current_pred)
- lru  out  2  combinational: pseudo-LRU victim way
- tag_write  in  4  one-hot per way: tag←wb_pc, valid←1, ctr←pred_update
- data_write  in  4  one-hot per way: target←wb_target
- pred_write  in  4  one-hot per way: ctr←pred_update
- pred_update  in  2  new counter value
- lru_write  in  1  touch the written way in the PLRU tree

## Operation
- Storage per way i: valid[i], tag[i], target[i], ctr[i].
- Match rule: valid[i] && tag[i]==pc. Multiple matches cannot occur by construction. If they do, the lowest-index way wins.
- Fetch port: combinational match on fetch_pc. Results register at the clock edge when !stall.
  - fetch_valid=0 registers pred_valid=0 and zeros all other fetch outputs.
- flush overrides stall: next edge sets pred_valid=0, pred_taken=0, pred_hit=0, pred_target=0, pred_way=0, pred_ctr=0.
- Writes: each of tag_write, data_write and pred_write is zero- or one-hot. Non-one-hot values are illegal and must fire an assertion.
  - tag_write and pred_write to the same way in one cycle both load ctr←pred_update; this is consistent.
- Written way for the PLRU touch = index of the set bit in (tag_write|data_write|pred_write).
- PLRU: 3-bit tree {b0 root, b1 ways 0/1, b2 ways 2/3}.
  - Touch way w: b0←~w[1]; if w[1]=0 then b1←~w[0], else b2←~w[0].
  - Victim: b0=0 → way {0,b1}; b0=1 → way {1,b2}.
- Touch sources: lru_write (WB) and a registered fetch hit (fetch_valid && hit && !stall && !flush).
  - If both occur in one cycle, only the WB touch is applied.
- Counters: the 2-bit saturating value is supplied externally. This block only stores pred_update.

## Timing
- Reset (asynchronous, rst_n=0):
  - valid[3:0]=0, ctr=00 for all ways, tags/targets=0, PLRU=000.
  - All registered outputs 0. Consequently wb_hit=0 and lru=00.
  - Deasserting reset mid-stream: first lookup after release misses.
- Fetch latency: fetch_pc at cycle N → pred_* valid after edge N+1. Outputs hold unchanged for every cycle stall=1.
- WB port: zero latency, purely combinational from wb_pc and current state.
- Writes take effect at the edge. A fetch or WB lookup in the same cycle as a write sees pre-write contents; there is no bypass.
- A write to way k in cycle N is visible to lookups from cycle N+1.

## Test plan
- Reset then fetch_pc=0x3000, fetch_valid=1 → next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0; wb_hit=0, lru=0.
- Allocate: wb_pc=0x3000, wb_target=0x3040, tag_write=0001, data_write=0001, pred_update=01, lru_write=1 → wb_hit=1, wb_way=0, wb_ctr=01, lru=2. Fetch 0x3000 → pred_hit=1, pred_taken=0, pred_target=0x3040.
- Train: pred_write=0001 with pred_update=10 → fetch 0x3000 gives pred_taken=1, pred_ctr=10.
- Fill 4 ways with lru_write each time, then touch way 0 via a fetch hit → lru=2 (way 2). Allocating a 5th PC into way 2 evicts the old tag, so a lookup of the old PC misses.
- Same cycle: write way 1 with tag 0x4000 while fetching 0x4000 → registered pred_hit=0. Fetch again next cycle → pred_hit=1, pred_way=1.
- Stall 3 cycles with fetch_pc changing → pred_* held. Assert flush together with stall → pred_valid=0 after the edge. Assert rst_n=0 mid-run → all outputs 0 immediately and all ways invalid.
